muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit sitting beside the combinational ALU in the execute stage. It accepts two 32-bit operands and a funct3 code, runs a 32-step shift-add multiply or restoring divide, and returns one 32-bit result through a start/busy/done handshake. The pipeline stalls on Busy. Kill aborts an in-flight operation on flush.

---
 rtl/rv32m_pkg.sv | 21 ++
 rtl/muldiv_unit_if.sv | 17 +
 rtl/muldiv_step.sv | 34 +++
 rtl/muldiv_unit.sv | 140 ++++++++++++++
 tb/tb_muldiv_unit.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/rv32m_pkg.sv
// rtl/rv32m_pkg.sv - shared RV32M constants, funct3 codes and FSM state encoding
package rv32m_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - start/busy/done request bus between execute stage and muldiv_unit
interface muldiv_unit_if;
  import rv32m_pkg::*;

  logic            Start;
  logic            Kill;
  logic [2:0]      Funct3;
  logic [XLEN-1:0] A;
  logic [XLEN-1:0] B;
  logic            Busy;
  logic            Done;
  logic [XLEN-1:0] Result;

  modport master (output Start, Kill, Funct3, A, B, input Busy, Done, Result);
  modport slave  (input Start, Kill, Funct3, A, B, output Busy, Done, Result);

endinterface

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one iteration of shift-add multiply or restoring divide
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic              is_div_i,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   opb_i,
  output logic [2*XLEN-1:0] acc_o
);

  logic [XLEN:0] mul_sum;
  logic [XLEN:0] div_diff;
  logic          div_ge;

  // Multiply: acc = {partial_hi, remaining multiplier bits}
  assign mul_sum = acc_i[0] ? ({1'b0, acc_i[2*XLEN-1:XLEN]} + {1'b0, opb_i})
                            : {1'b0, acc_i[2*XLEN-1:XLEN]};

  // Divide: acc = {remainder, quotient}; a set top bit means the shifted remainder
  // already exceeds any 32-bit divisor, so the trial subtract cannot borrow.
  assign div_diff = {1'b0, acc_i[2*XLEN-2:XLEN-1]} - {1'b0, opb_i};
  assign div_ge   = acc_i[2*XLEN-1] | ~div_diff[XLEN];

  always_comb begin
    acc_o = '0;
    if (is_div_i) begin
      if (div_ge) acc_o = {div_diff[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
      else        acc_o = {acc_i[2*XLEN-2:0], 1'b0};
    end else begin
      acc_o = {mul_sum, acc_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit with start/busy/done handshake
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input logic          clk,
  input logic          reset,
  muldiv_unit_if.slave bus
);
  import rv32m_pkg::*;

  state_e            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [2:0]        f3_q, f3_d;
  logic              neg_q, neg_d;
  logic              rneg_q, rneg_d;
  logic              spec_q, spec_d;
  logic [XLEN-1:0]   res_q, res_d;
  logic              done_q, done_d;
  logic [2*XLEN-1:0] step_acc;

  logic            a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            b_zero, div_ovf, special;
  logic [XLEN-1:0] spec_val;

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, fix_val;

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div_i (f3_q[2]),
    .acc_i    (acc_q),
    .opb_i    (opb_q),
    .acc_o    (step_acc)
  );

  assign a_signed = (bus.Funct3 == F3_MULH) || (bus.Funct3 == F3_MULHSU) ||
                    (bus.Funct3 == F3_DIV)  || (bus.Funct3 == F3_REM);
  assign b_signed = (bus.Funct3 == F3_MULH) || (bus.Funct3 == F3_DIV) ||
                    (bus.Funct3 == F3_REM);
  assign a_neg = a_signed & bus.A[XLEN-1];
  assign b_neg = b_signed & bus.B[XLEN-1];
  assign mag_a = a_neg ? (~bus.A + 1'b1) : bus.A;
  assign mag_b = b_neg ? (~bus.B + 1'b1) : bus.B;

  assign b_zero  = (bus.B == '0);
  assign div_ovf = ((bus.Funct3 == F3_DIV) || (bus.Funct3 == F3_REM)) &&
                   (bus.A == {1'b1, {(XLEN-1){1'b0}}}) && (bus.B == '1);
  assign special = bus.Funct3[2] & (b_zero | div_ovf);
  // funct3[1] separates REM/REMU from DIV/DIVU
  assign spec_val = b_zero ? (bus.Funct3[1] ? bus.A : '1)
                           : (bus.Funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});

  assign prod = neg_q  ? (~acc_q + 1'b1) : acc_q;
  assign quo  = neg_q  ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
  assign rem  = rneg_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];

  always_comb begin
    fix_val = '0;
    if (spec_q)             fix_val = acc_q[XLEN-1:0];
    else if (f3_q[2])       fix_val = f3_q[1] ? rem : quo;
    else if (f3_q == F3_MUL) fix_val = prod[XLEN-1:0];
    else                    fix_val = prod[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    f3_d    = f3_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    spec_d  = spec_q;
    res_d   = res_q;
    done_d  = 1'b0;
    if (bus.Kill) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.Start) begin
            f3_d    = bus.Funct3;
            opb_d   = mag_b;
            neg_d   = a_neg ^ b_neg;
            rneg_d  = a_neg;
            spec_d  = special;
            cnt_d   = '0;
            // special cases park their answer in the low half for FIX to forward
            acc_d   = {{XLEN{1'b0}}, special ? spec_val : mag_a};
            state_d = special ? S_FIX : S_CALC;
          end
        end
        S_CALC: begin
          acc_d = step_acc;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_d = S_FIX;
        end
        S_FIX: begin
          res_d   = fix_val;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opb_q   <= '0;
      f3_q    <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      spec_q  <= 1'b0;
      res_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      f3_q    <= f3_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      spec_q  <= spec_d;
      res_q   <= res_d;
      done_q  <= done_d;
    end
  end

  assign bus.Busy   = (state_q != S_IDLE);
  assign bus.Done   = done_q;
  assign bus.Result = res_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit
module tb_muldiv_unit;
  import rv32m_pkg::*;

  logic clk = 1'b0;
  logic reset;
  muldiv_unit_if bus();

  muldiv_unit dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Reference: plain integer arithmetic over the architectural rules
  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
    longint    sa, sb, ub, ua;
    logic [63:0] p;
    int        ia, ib, q;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    ia = $signed(a);
    ib = $signed(b);
    p  = '0;
    q  = 0;
    case (f3)
      F3_MUL:    begin p = ua * ub; return p[31:0]; end
      F3_MULH:   begin p = sa * sb; return p[63:32]; end
      F3_MULHSU: begin p = sa * ub; return p[63:32]; end
      F3_MULHU:  begin p = ua * ub; return p[63:32]; end
      F3_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        q = ia / ib; return q;
      end
      F3_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      F3_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        q = ia % ib; return q;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    @(negedge clk);
    bus.Start = 1'b1; bus.Funct3 = f3; bus.A = a; bus.B = b;
    @(posedge clk);
    @(negedge clk);
    bus.Start = 1'b0;
    bus.A = $urandom; bus.B = $urandom; bus.Funct3 = 3'($urandom);
    check("busy_after_e0", 32'(bus.Busy), 32'd1);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.Done) begin lat = n; break; end
    end
    res = bus.Result;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'(($urandom_range(1, 20)));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] res, prev, ra, rb;
    logic [2:0]  rf;
    int          lat, seen, exp_lat;

    reset = 1'b1;
    bus.Start = 1'b0; bus.Kill = 1'b0; bus.Funct3 = '0; bus.A = '0; bus.B = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset_busy",   32'(bus.Busy), 32'd0);
    check("reset_done",   32'(bus.Done), 32'd0);
    check("reset_result", bus.Result,    32'd0);

    vecs[0]  = '{F3_MUL,    32'd7,          32'd6,          32'd42,         33};
    vecs[1]  = '{F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  33};
    vecs[2]  = '{F3_MULH,   32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF,  33};
    vecs[3]  = '{F3_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  33};
    vecs[4]  = '{F3_DIV,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33};
    vecs[5]  = '{F3_REM,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33};
    vecs[6]  = '{F3_DIVU,   32'd100,        32'd7,          32'd14,         33};
    vecs[7]  = '{F3_REMU,   32'd100,        32'd7,          32'd2,          33};
    vecs[8]  = '{F3_DIV,    32'd5,          32'd0,          32'hFFFF_FFFF,  1};
    vecs[9]  = '{F3_REMU,   32'd123,        32'd0,          32'd123,        1};
    vecs[10] = '{F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
    vecs[11] = '{F3_REM,    32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          1};
    vecs[12] = '{F3_MULH,   32'h8000_0000,  32'h8000_0000,  32'h4000_0000,  33};
    vecs[13] = '{F3_DIVU,   32'd5,          32'd0,          32'hFFFF_FFFF,  1};

    foreach (vecs[i]) begin
      run_op(vecs[i].f3, vecs[i].a, vecs[i].b, res, lat);
      check($sformatf("vec%0d_result", i),  res,      vecs[i].exp);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
    end

    for (int i = 0; i < 40; i++) begin
      rf = 3'($urandom);
      ra = pick_operand();
      rb = pick_operand();
      run_op(rf, ra, rb, res, lat);
      exp_lat = (rf[2] && (rb == 0 || ((rf == F3_DIV || rf == F3_REM) &&
                 ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF))) ? 1 : 33;
      check($sformatf("rand%0d_f3%0d_%08h_%08h", i, rf, ra, rb), res, ref_model(rf, ra, rb));
      check($sformatf("rand%0d_latency", i), 32'(lat), 32'(exp_lat));
    end

    // Kill at cycle 10 of CALC
    prev = bus.Result;
    @(negedge clk);
    bus.Start = 1'b1; bus.Funct3 = F3_DIVU; bus.A = 32'd1000; bus.B = 32'd3;
    @(posedge clk);
    @(negedge clk);
    bus.Start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.Kill = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.Kill = 1'b0;
    check("kill_busy", 32'(bus.Busy), 32'd0);
    seen = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.Done) seen++;
    end
    check("kill_no_done",     32'(seen),  32'd0);
    check("kill_result_held", bus.Result, prev);

    // Start during Busy is ignored
    @(negedge clk);
    bus.Start = 1'b1; bus.Funct3 = F3_MUL; bus.A = 32'd3; bus.B = 32'd5;
    @(posedge clk);
    @(negedge clk);
    bus.Start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    bus.Start = 1'b1; bus.Funct3 = F3_DIVU; bus.A = 32'd0; bus.B = 32'd0;
    @(posedge clk);
    @(negedge clk);
    bus.Start = 1'b0;
    lat = -1;
    for (int n = 7; n <= 45; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.Done) begin lat = n; break; end
    end
    check("busy_start_result",  bus.Result, 32'd15);
    check("busy_start_latency", 32'(lat),   32'd33);
    @(posedge clk);
    @(negedge clk);
    check("busy_start_not_queued", 32'(bus.Busy), 32'd0);

    // Kill and Start together in IDLE
    bus.Kill = 1'b1; bus.Start = 1'b1; bus.Funct3 = F3_MUL; bus.A = 32'd2; bus.B = 32'd2;
    @(posedge clk);
    @(negedge clk);
    bus.Kill = 1'b0; bus.Start = 1'b0;
    check("kill_start_busy", 32'(bus.Busy), 32'd0);

    // Special ops back to back with Start held
    bus.Start = 1'b1; bus.Funct3 = F3_DIVU; bus.A = 32'd1; bus.B = 32'd0;
    for (int n = 0; n < 6; n++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("b2b_done_%0d", n), 32'(bus.Done), 32'(n % 2));
    end
    bus.Start = 1'b0;
    @(posedge clk);
    @(negedge clk);

    // Reset mid-CALC
    bus.Start = 1'b1; bus.Funct3 = F3_MUL; bus.A = 32'd9; bus.B = 32'd9;
    @(posedge clk);
    @(negedge clk);
    bus.Start = 1'b0;
    repeat (11) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_busy",   32'(bus.Busy), 32'd0);
    check("rst_mid_done",   32'(bus.Done), 32'd0);
    check("rst_mid_result", bus.Result,    32'd0);
    run_op(F3_DIVU, 32'd9, 32'd3, res, lat);
    check("post_rst_result",  res,      32'd3);
    check("post_rst_latency", 32'(lat), 32'd33);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end

endmodule
